// File: rtl/hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// hazard_ctrl_if : pipeline <-> hazard controller signal bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Register addresses and write enables seen by the hazard logic
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       RA1E;
    logic [3:0]       RA2E;
    logic [3:0]       WA3E;
    logic [3:0]       WA3M;
    logic [3:0]       WA3W;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             PCSrcD;
    logic             PCSrcE;
    logic             PCSrcM;
    logic             PCSrcW;
    logic             BranchTakenE;
    logic             MemReqM;
    logic             DReadyM;
    logic             cntClr;

    // Controls back to the pipeline
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             memBusy;
    logic             memError;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output MemReqM, DReadyM, cntClr,
        input  ForwardAE, ForwardBE,
        input  stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW,
        input  memBusy, memError, StallCount, FlushCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  MemReqM, DReadyM, cntClr,
        output ForwardAE, ForwardBE,
        output stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW,
        output memBusy, memError, StallCount, FlushCount
    );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl : stall/flush/forward control for the 5-stage pipeline,
//               data-memory freeze with timeout, saturating event counters
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  wire logic     clk,
    input  wire logic     resetN,
    hazard_ctrl_if.slave  hz
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_WAIT = 2'd1;
    localparam logic [1:0] C_ST_ERR  = 2'd2;

    localparam logic [WCNT_W-1:0] C_WCNT_ONE = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] C_TIMEOUT  = WCNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [3:0] C_PC_REG = 4'd15;

    //--------------------------------------------------------------------------
    // Forwarding
    //--------------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic       rw_m,
        input logic [3:0] wa_m,
        input logic       rw_w,
        input logic [3:0] wa_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        // The PC register is never forwarded; it is always read from its own path
        if (rw_m && (ra == wa_m) && (wa_m != C_PC_REG)) begin
            sel = 2'b10;
        end else if (rw_w && (ra == wa_w) && (wa_w != C_PC_REG)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_fwd_a = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
    assign w_fwd_b = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);

    //--------------------------------------------------------------------------
    // Base hazards
    //--------------------------------------------------------------------------
    logic w_ldr_stall;
    logic w_pc_pend;
    logic w_stall_f0;
    logic w_stall_d0;
    logic w_flush_d0;
    logic w_flush_e0;

    assign w_ldr_stall = hz.MemtoRegE & hz.RegWriteE &
                         ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
    assign w_pc_pend   = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
    assign w_stall_f0  = w_ldr_stall | w_pc_pend;
    assign w_stall_d0  = w_ldr_stall;
    assign w_flush_d0  = w_pc_pend | hz.PCSrcW | hz.BranchTakenE;
    assign w_flush_e0  = w_ldr_stall | hz.BranchTakenE;

    //--------------------------------------------------------------------------
    // Memory wait FSM
    //--------------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              w_not_ready;

    assign w_not_ready = hz.MemReqM & ~hz.DReadyM;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= C_ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_not_ready) begin
                    state_d = C_ST_WAIT;
                    wcnt_d  = C_WCNT_ONE;
                end
            end
            C_ST_WAIT: begin
                if (hz.DReadyM) begin
                    state_d = C_ST_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == C_TIMEOUT) begin
                    state_d = C_ST_ERR;
                end else begin
                    wcnt_d  = wcnt_q + C_WCNT_ONE;
                end
            end
            C_ST_ERR: begin
                state_d = C_ST_ERR;
            end
            default: begin
                state_d = C_ST_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // The combinational not-ready term covers the first miss while still IDLE
    logic w_mem_freeze;
    logic w_mem_error;
    logic w_stall_f;
    logic w_stall_d;
    logic w_stall_e;
    logic w_stall_m;
    logic w_flush_d;
    logic w_flush_e;
    logic w_flush_w;

    always_comb begin
        w_mem_error  = (state_q == C_ST_ERR);
        w_mem_freeze = w_not_ready | w_mem_error;
        if (w_mem_freeze) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_d = 1'b0;
            w_flush_e = 1'b0;
            w_flush_w = 1'b1;
        end else begin
            w_stall_f = w_stall_f0;
            w_stall_d = w_stall_d0;
            w_stall_e = 1'b0;
            w_stall_m = 1'b0;
            w_flush_d = w_flush_d0;
            w_flush_e = w_flush_e0;
            w_flush_w = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Saturating performance counters
    //--------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic             w_flush_ev;

    assign w_flush_ev = w_flush_d | w_flush_e;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.cntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (w_stall_f && (stall_cnt_q != C_CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + C_CNT_ONE;
            end
            if (w_flush_ev && (flush_cnt_q != C_CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign hz.ForwardAE  = w_fwd_a;
    assign hz.ForwardBE  = w_fwd_b;
    assign hz.stallF     = w_stall_f;
    assign hz.stallD     = w_stall_d;
    assign hz.stallE     = w_stall_e;
    assign hz.stallM     = w_stall_m;
    assign hz.flushD     = w_flush_d;
    assign hz.flushE     = w_flush_e;
    assign hz.flushW     = w_flush_w;
    assign hz.memBusy    = w_mem_freeze;
    assign hz.memError   = w_mem_error;
    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;

    logic clk;
    logic resetN;
    int   n_vec = 0;
    int   n_err = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif();

    hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .hz     (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {stallF, stallD, stallE, stallM, flushW, flushD, flushE, memBusy}
    logic [7:0] ctl;
    assign ctl = {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                  hif.flushW, hif.flushD, hif.flushE, hif.memBusy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hif.RA1D = 4'd0; hif.RA2D = 4'd0; hif.RA1E = 4'd0; hif.RA2E = 4'd0;
        hif.WA3E = 4'd0; hif.WA3M = 4'd0; hif.WA3W = 4'd0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0;
        hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b0; hif.PCSrcM = 1'b0; hif.PCSrcW = 1'b0;
        hif.BranchTakenE = 1'b0;
        hif.MemReqM = 1'b0; hif.DReadyM = 1'b0;
        hif.cntClr = 1'b0;
    endtask

    task automatic clear_counters();
        hif.cntClr = 1'b1;
        tick();
        hif.cntClr = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        set_idle();
        tick();
        tick();
        n_vec++; if (hif.StallCount !== 8'd0) begin n_err++; $display("FAIL rst_stallcnt: got %0d want 0", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'd0) begin n_err++; $display("FAIL rst_flushcnt: got %0d want 0", hif.FlushCount); end
        n_vec++; if (hif.memError !== 1'b0) begin n_err++; $display("FAIL rst_memerr: got %b want 0", hif.memError); end
        n_vec++; if (ctl !== 8'b0000_0000) begin n_err++; $display("FAIL rst_ctl: got %b want 00000000", ctl); end
        n_vec++; if ({hif.ForwardAE, hif.ForwardBE} !== 4'b0000) begin n_err++; $display("FAIL rst_fwd: got %b want 0000", {hif.ForwardAE, hif.ForwardBE}); end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        set_idle();
        hif.RegWriteM = 1'b1; hif.WA3M = 4'd3; hif.RegWriteW = 1'b1; hif.WA3W = 4'd3; hif.RA1E = 4'd3;
        #1;
        n_vec++; if (hif.ForwardAE !== 2'b10) begin n_err++; $display("FAIL fwd_a_m: got %b want 10", hif.ForwardAE); end
        n_vec++; if (hif.ForwardBE !== 2'b00) begin n_err++; $display("FAIL fwd_b_none: got %b want 00", hif.ForwardBE); end
        hif.RegWriteM = 1'b0;
        #1;
        n_vec++; if (hif.ForwardAE !== 2'b01) begin n_err++; $display("FAIL fwd_a_w: got %b want 01", hif.ForwardAE); end
        hif.RegWriteM = 1'b1; hif.WA3M = 4'd15; hif.WA3W = 4'd15; hif.RA1E = 4'd15;
        #1;
        n_vec++; if (hif.ForwardAE !== 2'b00) begin n_err++; $display("FAIL fwd_a_r15: got %b want 00", hif.ForwardAE); end
        hif.RA1E = 4'd2; hif.RA2E = 4'd7; hif.WA3M = 4'd7; hif.WA3W = 4'd7;
        #1;
        n_vec++; if (hif.ForwardBE !== 2'b10) begin n_err++; $display("FAIL fwd_b_m: got %b want 10", hif.ForwardBE); end
        n_vec++; if (hif.ForwardAE !== 2'b00) begin n_err++; $display("FAIL fwd_a_miss: got %b want 00", hif.ForwardAE); end
        hif.RA2E = 4'd9; hif.WA3W = 4'd9; hif.WA3M = 4'd4;
        #1;
        n_vec++; if (hif.ForwardBE !== 2'b01) begin n_err++; $display("FAIL fwd_b_w: got %b want 01", hif.ForwardBE); end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        clear_counters();
        n_vec++; if (hif.StallCount !== 8'd0) begin n_err++; $display("FAIL lu_cnt0: got %0d want 0", hif.StallCount); end
        hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WA3E = 4'd5; hif.RA2D = 4'd5; hif.RA1D = 4'd1;
        #1;
        // stallF, stallD, flushE set; nothing else
        n_vec++; if (ctl !== 8'b1100_0010) begin n_err++; $display("FAIL lu_ctl: got %b want 11000010", ctl); end
        tick();
        set_idle();
        #1;
        n_vec++; if (hif.StallCount !== 8'd1) begin n_err++; $display("FAIL lu_stallcnt: got %0d want 1", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'd1) begin n_err++; $display("FAIL lu_flushcnt: got %0d want 1", hif.FlushCount); end
        n_vec++; if (ctl !== 8'b0000_0000) begin n_err++; $display("FAIL lu_release: got %b want 00000000", ctl); end
    endtask

    task automatic test_branch_ldr();
        clear_counters();
        hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WA3E = 4'd6; hif.RA1D = 4'd6;
        hif.BranchTakenE = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            #1;
            n_vec++; if (ctl !== 8'b1100_0110) begin n_err++; $display("FAIL br_ctl[%0d]: got %b want 11000110", i, ctl); end
            tick();
            n_vec++; if (hif.FlushCount !== 8'(i)) begin n_err++; $display("FAIL br_flushcnt[%0d]: got %0d want %0d", i, hif.FlushCount, i); end
        end
        set_idle();
        tick();
    endtask

    task automatic test_pc_write();
        clear_counters();
        for (int i = 0; i < 4; i++) begin
            hif.PCSrcD = (i == 0); hif.PCSrcE = (i == 1);
            hif.PCSrcM = (i == 2); hif.PCSrcW = (i == 3);
            #1;
            n_vec++; if (hif.stallF !== (i < 3)) begin n_err++; $display("FAIL pc_stallF[%0d]: got %b want %b", i, hif.stallF, (i < 3)); end
            n_vec++; if (hif.flushD !== 1'b1) begin n_err++; $display("FAIL pc_flushD[%0d]: got %b want 1", i, hif.flushD); end
            tick();
        end
        set_idle();
        #1;
        n_vec++; if (hif.StallCount !== 8'd3) begin n_err++; $display("FAIL pc_stallcnt: got %0d want 3", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'd4) begin n_err++; $display("FAIL pc_flushcnt: got %0d want 4", hif.FlushCount); end
        n_vec++; if (ctl !== 8'b0000_0000) begin n_err++; $display("FAIL pc_release: got %b want 00000000", ctl); end
    endtask

    task automatic test_mem_wait();
        clear_counters();
        hif.BranchTakenE = 1'b1;
        hif.MemReqM = 1'b1; hif.DReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (ctl !== 8'b1111_1001) begin n_err++; $display("FAIL mw_freeze[%0d]: got %b want 11111001", i, ctl); end
            tick();
        end
        n_vec++; if (hif.StallCount !== 8'd3) begin n_err++; $display("FAIL mw_stallcnt: got %0d want 3", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'd0) begin n_err++; $display("FAIL mw_flushcnt: got %0d want 0", hif.FlushCount); end
        hif.DReadyM = 1'b1;
        #1;
        n_vec++; if (ctl !== 8'b0000_0110) begin n_err++; $display("FAIL mw_release: got %b want 00000110", ctl); end
        tick();
        n_vec++; if (hif.FlushCount !== 8'd1) begin n_err++; $display("FAIL mw_flushcnt2: got %0d want 1", hif.FlushCount); end
        n_vec++; if (hif.memError !== 1'b0) begin n_err++; $display("FAIL mw_memerr: got %b want 0", hif.memError); end
        set_idle();
        tick();
    endtask

    task automatic test_timeout_reset();
        clear_counters();
        hif.MemReqM = 1'b1; hif.DReadyM = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_vec++; if (hif.memError !== (i >= 5)) begin n_err++; $display("FAIL to_memerr[%0d]: got %b want %b", i, hif.memError, (i >= 5)); end
        end
        hif.MemReqM = 1'b0; hif.DReadyM = 1'b1; hif.BranchTakenE = 1'b1;
        #1;
        n_vec++; if (ctl !== 8'b1111_1001) begin n_err++; $display("FAIL to_err_ctl: got %b want 11111001", ctl); end
        n_vec++; if (hif.StallCount !== 8'd5) begin n_err++; $display("FAIL to_stallcnt: got %0d want 5", hif.StallCount); end
        tick();
        n_vec++; if (hif.memError !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", hif.memError); end
        #2;
        resetN = 1'b0;
        #1;
        n_vec++; if (ctl !== 8'b0000_0110) begin n_err++; $display("FAIL to_rst_ctl: got %b want 00000110", ctl); end
        n_vec++; if (hif.memError !== 1'b0) begin n_err++; $display("FAIL to_rst_memerr: got %b want 0", hif.memError); end
        n_vec++; if (hif.StallCount !== 8'd0) begin n_err++; $display("FAIL to_rst_stallcnt: got %0d want 0", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'd0) begin n_err++; $display("FAIL to_rst_flushcnt: got %0d want 0", hif.FlushCount); end
        #2;
        resetN = 1'b1;
        set_idle();
        tick();
    endtask

    task automatic test_saturation_clear();
        clear_counters();
        hif.PCSrcD = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        n_vec++; if (hif.StallCount !== 8'hFF) begin n_err++; $display("FAIL sat_stall255: got %0d want 255", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'hFF) begin n_err++; $display("FAIL sat_flush255: got %0d want 255", hif.FlushCount); end
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (hif.StallCount !== 8'hFF) begin n_err++; $display("FAIL sat_stallhold: got %0d want 255", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'hFF) begin n_err++; $display("FAIL sat_flushhold: got %0d want 255", hif.FlushCount); end
        hif.cntClr = 1'b1;
        tick();
        n_vec++; if (hif.StallCount !== 8'd0) begin n_err++; $display("FAIL clr_stall: got %0d want 0", hif.StallCount); end
        n_vec++; if (hif.FlushCount !== 8'd0) begin n_err++; $display("FAIL clr_flush: got %0d want 0", hif.FlushCount); end
        hif.cntClr = 1'b0;
        tick();
        n_vec++; if (hif.StallCount !== 8'd1) begin n_err++; $display("FAIL clr_resume: got %0d want 1", hif.StallCount); end
        set_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_ldr();
        test_pc_write();
        test_mem_wait();
        test_timeout_reset();
        test_saturation_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
